mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (data load/store fed from the EX/MEM pipeline register). A three-state FSM accepts one transaction at a time, issues it with a req/ready handshake, and returns the response to the granted requester. It drives the stall signals that freeze the front end and the EX/MEM register while their access is outstanding. Data requests take priority, and a streak limit prevents fetch starvation.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the data stage.
// Serves one transaction at a time; data wins unless fetch has been starved for MAX_DATA_STREAK grants.
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [31:0]       o_if_rdata,
  output logic              o_if_valid,
  input  logic              i_dmem_ren,
  input  logic              i_dmem_wen,
  input  logic [ADDR_W-1:0] i_dmem_addr,
  input  logic [31:0]       i_dmem_wdata,
  input  logic [3:0]        i_dmem_mask,
  output logic [31:0]       o_dmem_rdata,
  output logic              o_dmem_valid,
  output logic              o_stall_if,
  output logic              o_stall_mem,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_mask,
  input  logic              i_mem_ready,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] streak;
  logic          gnt_data;
  logic          dreq, grant_data, grant_if;

  always_comb begin
    dreq       = i_dmem_ren | i_dmem_wen;
    grant_data = (state == IDLE) && dreq && (!i_if_req || (streak < STREAK_MAX));
    grant_if   = (state == IDLE) && !grant_data && i_if_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_data || grant_if) state_nxt = ISSUE;
      ISSUE:   if (i_mem_ready)            state_nxt = WAIT;
      WAIT:    if (i_mem_rvalid)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stalls are gated by reset so every output reads 0 while rst is low.
  always_comb begin
    o_mem_req   = (state == ISSUE);
    o_stall_if  = rst & i_if_req & ~o_if_valid;
    o_stall_mem = rst & dreq & ~o_dmem_valid;
  end

  // Request fields latch at grant and stay stable through the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_mask  <= '0;
      gnt_data    <= 1'b0;
      streak      <= '0;
    end else if (grant_data) begin
      o_mem_we    <= i_dmem_wen;
      o_mem_addr  <= i_dmem_addr;
      o_mem_wdata <= i_dmem_wen ? i_dmem_wdata : 32'h0;
      o_mem_mask  <= i_dmem_wen ? i_dmem_mask : 4'hF;
      gnt_data    <= 1'b1;
      if (!i_if_req)                 streak <= '0;
      else if (streak != STREAK_MAX) streak <= streak + 1'b1;
    end else if (grant_if) begin
      o_mem_we    <= 1'b0;
      o_mem_addr  <= i_if_addr;
      o_mem_wdata <= 32'h0;
      o_mem_mask  <= 4'hF;
      gnt_data    <= 1'b0;
      streak      <= '0;
    end
  end

  // Completion: route response to the granted requester, one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_if_valid   <= 1'b0;
      o_dmem_valid <= 1'b0;
      o_if_rdata   <= '0;
      o_dmem_rdata <= '0;
    end else begin
      o_if_valid   <= 1'b0;
      o_dmem_valid <= 1'b0;
      if (state == WAIT && i_mem_rvalid) begin
        if (gnt_data) begin
          o_dmem_rdata <= i_mem_rdata;
          o_dmem_valid <= 1'b1;
        end else begin
          o_if_rdata   <= i_mem_rdata;
          o_if_valid   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_valid;
  logic        i_dmem_ren, i_dmem_wen;
  logic [31:0] i_dmem_addr, i_dmem_wdata;
  logic [3:0]  i_dmem_mask;
  logic [31:0] o_dmem_rdata;
  logic        o_dmem_valid;
  logic        o_stall_if, o_stall_mem;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready, i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DATA_STREAK(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_rdata(o_if_rdata), .o_if_valid(o_if_valid),
    .i_dmem_ren(i_dmem_ren), .i_dmem_wen(i_dmem_wen),
    .i_dmem_addr(i_dmem_addr), .i_dmem_wdata(i_dmem_wdata), .i_dmem_mask(i_dmem_mask),
    .o_dmem_rdata(o_dmem_rdata), .o_dmem_valid(o_dmem_valid),
    .o_stall_if(o_stall_if), .o_stall_mem(o_stall_mem),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  typedef struct {
    logic        if_req, ren, wen;
    logic [31:0] daddr, wdata;
    logic [3:0]  mask;
    logic [31:0] iaddr;
    logic        ready, rvalid;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_mask;
    logic        e_dval;
    logic [31:0] e_drd;
    logic        e_ival;
    logic [31:0] e_ird;
    logic        e_sif, e_smem;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    i_if_req = 0; i_if_addr = 0; i_dmem_ren = 0; i_dmem_wen = 0;
    i_dmem_addr = 0; i_dmem_wdata = 0; i_dmem_mask = 0;
    i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic seq[6];
    int   n;

    // Load only, then simultaneous IF + data requests.
    vt[0]  = '{0,1,0,32'h100,0,0,0,1,0,0,           0,0,0,0,0,       0,0,0,0,            0,1};
    vt[1]  = '{0,1,0,32'h100,0,0,0,1,0,0,           1,0,32'h100,0,4'hF, 0,0,0,0,         0,1};
    vt[2]  = '{0,1,0,32'h100,0,0,0,1,1,32'hDEADBEEF, 0,0,0,0,0,       0,0,0,0,            0,1};
    vt[3]  = '{0,0,0,0,0,0,0,1,0,0,                 0,0,0,0,0,       1,32'hDEADBEEF,0,0, 0,0};
    vt[4]  = '{0,0,0,0,0,0,0,1,0,0,                 0,0,0,0,0,       0,0,0,0,            0,0};
    vt[5]  = '{1,1,0,32'h104,0,0,32'h40,1,0,0,      0,0,0,0,0,       0,0,0,0,            1,1};
    vt[6]  = '{1,1,0,32'h104,0,0,32'h40,1,0,0,      1,0,32'h104,0,4'hF, 0,0,0,0,         1,1};
    vt[7]  = '{1,1,0,32'h104,0,0,32'h40,1,1,32'hA5A50001, 0,0,0,0,0, 0,0,0,0,            1,1};
    vt[8]  = '{1,0,0,0,0,0,32'h40,1,0,0,            0,0,0,0,0,       1,32'hA5A50001,0,0, 1,0};
    vt[9]  = '{1,0,0,0,0,0,32'h40,1,0,0,            1,0,32'h40,0,4'hF, 0,0,0,0,          1,0};
    vt[10] = '{1,0,0,0,0,0,32'h40,1,1,32'h13,       0,0,0,0,0,       0,0,0,0,            1,0};
    vt[11] = '{0,0,0,0,0,0,0,1,0,0,                 0,0,0,0,0,       0,0,1,32'h13,       0,0};
    vt[12] = '{0,0,0,0,0,0,0,1,0,0,                 0,0,0,0,0,       0,0,0,0,            0,0};

    // Reset: all outputs 0 even with requests asserted.
    clr_inputs();
    rst = 1'b0;
    i_if_req = 1; i_dmem_ren = 1;
    #2;
    chk("reset_outputs", {o_mem_req, o_mem_we, o_mem_addr, o_mem_mask, o_dmem_valid, o_if_valid,
                          o_stall_if, o_stall_mem}, '0);
    clr_inputs();
    mid();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      i_if_req = vt[i].if_req; i_dmem_ren = vt[i].ren; i_dmem_wen = vt[i].wen;
      i_dmem_addr = vt[i].daddr; i_dmem_wdata = vt[i].wdata; i_dmem_mask = vt[i].mask;
      i_if_addr = vt[i].iaddr; i_mem_ready = vt[i].ready; i_mem_rvalid = vt[i].rvalid;
      i_mem_rdata = vt[i].rdata;
      mid();
      chk($sformatf("vec%0d_ctrl", i), {o_mem_req, o_dmem_valid, o_if_valid, o_stall_if, o_stall_mem},
          {vt[i].e_req, vt[i].e_dval, vt[i].e_ival, vt[i].e_sif, vt[i].e_smem});
      if (vt[i].e_req)
        chk($sformatf("vec%0d_fields", i), {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_mask},
            {vt[i].e_we, vt[i].e_addr, vt[i].e_wdata, vt[i].e_mask});
      if (vt[i].e_dval) chk($sformatf("vec%0d_drdata", i), o_dmem_rdata, vt[i].e_drd);
      if (vt[i].e_ival) chk($sformatf("vec%0d_irdata", i), o_if_rdata, vt[i].e_ird);
      tick();
    end
    clr_inputs();

    // Store with backpressure; ren also high to show write wins.
    i_dmem_ren = 1; i_dmem_wen = 1; i_dmem_addr = 32'h200;
    i_dmem_wdata = 32'h12345678; i_dmem_mask = 4'b0011;
    mid();
    chk("st_idle_noreq", o_mem_req, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) i_mem_ready = 1;
      mid();
      chk("st_hold", {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_mask},
          {1'b1, 1'b1, 32'h200, 32'h12345678, 4'h3});
      chk("st_stall", o_stall_mem, 1);
      tick();
    end
    i_mem_ready = 0; i_mem_rvalid = 1; i_mem_rdata = 0;
    mid();
    chk("st_wait", {o_mem_req, o_dmem_valid, o_stall_mem}, 3'b001);
    tick();
    clr_inputs();
    mid();
    chk("st_ack", {o_dmem_valid, o_stall_mem, o_if_valid}, 3'b100);
    chk("if_rdata_hold", o_if_rdata, 32'h13);
    tick();
    mid();
    chk("st_pulse_once", o_dmem_valid, 0);
    tick();

    // Starvation: fetch held, data continuously requested.
    i_if_req = 1; i_if_addr = 32'h80; i_dmem_ren = 1; i_dmem_addr = 32'h300;
    i_mem_ready = 1; i_mem_rvalid = 1; i_mem_rdata = 32'h77;
    n = 0;
    for (int k = 0; k < 6; k++) seq[k] = 1'bx;
    for (int c = 0; c < 40 && n < 6; c++) begin
      mid();
      if (o_mem_req) begin
        seq[n] = (o_mem_addr == 32'h300);
        n++;
      end
      tick();
    end
    chk("starve_count", n, 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("starve_grant%0d_is_data", k), seq[k], (k == 4) ? 1'b0 : 1'b1);
    i_if_req = 0; i_dmem_ren = 0;
    repeat (4) tick();
    clr_inputs();
    tick();

    // Reset asserted while in WAIT.
    i_dmem_ren = 1; i_dmem_addr = 32'h400; i_mem_ready = 1;
    tick();
    tick();
    i_if_req = 1;
    mid();
    chk("rst_pre_stalls", {o_stall_if, o_stall_mem, o_mem_addr}, {1'b1, 1'b1, 32'h400});
    #1 rst = 1'b0;
    #1;
    chk("rst_async_outputs", {o_mem_req, o_mem_we, o_mem_addr, o_mem_mask, o_dmem_valid, o_if_valid,
                              o_stall_if, o_stall_mem}, '0);
    chk("rst_rdata", {o_dmem_rdata, o_if_rdata}, '0);
    clr_inputs();
    mid();
    rst = 1'b1;
    tick();
    i_dmem_ren = 1; i_dmem_addr = 32'h500; i_mem_ready = 1;
    mid();
    chk("post_rst_idle", o_mem_req, 0);
    tick();
    mid();
    chk("post_rst_issue", {o_mem_req, o_mem_we, o_mem_addr, o_mem_mask}, {1'b1, 1'b0, 32'h500, 4'hF});
    tick();
    i_mem_rvalid = 1; i_mem_rdata = 32'h55;
    tick();
    clr_inputs();
    mid();
    chk("post_rst_done", {o_dmem_valid, o_dmem_rdata}, {1'b1, 32'h55});
    tick();

    // Flush: ren dropped during WAIT, then a stray rvalid in IDLE.
    i_dmem_ren = 1; i_dmem_addr = 32'h600; i_mem_ready = 1;
    tick();
    tick();
    i_dmem_ren = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hCAFEF00D;
    mid();
    chk("flush_nostall", o_stall_mem, 0);
    tick();
    i_mem_rvalid = 0;
    mid();
    chk("flush_pulse", {o_dmem_valid, o_dmem_rdata}, {1'b1, 32'hCAFEF00D});
    tick();
    i_mem_rvalid = 1; i_mem_rdata = 32'h11111111;
    for (int k = 0; k < 2; k++) begin
      mid();
      chk("stray_rvalid", {o_mem_req, o_dmem_valid, o_if_valid, o_dmem_rdata},
          {3'b000, 32'hCAFEF00D});
      tick();
    end
    clr_inputs();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
